// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_pkg
//  Description : Shared FSM state encoding and default sizing constants for
//                the ADC capture block.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    localparam int unsigned c_DATA_W_DEF  = 14;
    localparam int unsigned c_ADDR_W_DEF  = 10;
    localparam int unsigned c_CLK_DIV_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ram
//  Description : Simple dual-port sample buffer, one write port and one
//                registered read port. A same-cycle read of the address being
//                written returns the previous contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_ram #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; only the output register is cleared by reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture
//  Description : ADC sample-clock generator and triggered capture engine with
//                pre-trigger ring buffer and CPU read-back port.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W_DEF,
    parameter int ADDR_W  = c_ADDR_W_DEF,
    parameter int CLK_DIV = c_CLK_DIV_DEF
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    output logic              adc_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pretrig,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [7:0]        c_DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0]        c_DIV_HALF  = 8'(CLK_DIV / 2);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    logic [7:0]        r_div_cnt;
    logic [7:0]        w_div_nxt;
    logic              w_div_last;
    logic              r_adc_clk;
    logic [DATA_W-1:0] r_sample;
    logic              r_sample_vld;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_pretrig;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_vld;

    logic [ADDR_W-1:0] w_post_len;
    logic              w_post_more;
    logic              w_rise;
    logic              w_fall;
    logic              w_trig;
    logic              w_wr_en;

    assign w_div_last = (r_div_cnt == c_DIV_LAST);
    assign w_div_nxt  = w_div_last ? 8'd0 : r_div_cnt + 8'd1;

    // Free-running divider; adc_clk tracks the count it is registered with.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= 8'd0;
            r_adc_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_adc_clk <= (w_div_nxt < c_DIV_HALF);
        end
    end

    // Capture the ADC word on the last divider count; the strobe follows it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            r_sample_vld <= w_div_last;
            if (w_div_last) begin
                r_sample <= adc_data;
            end
        end
    end

    // Post-trigger length leaves exactly pretrig older words in the ring.
    assign w_post_len  = c_LAST_ADDR - r_pretrig;
    assign w_post_more = (r_cnt != w_post_len);
    assign w_rise      = (r_prev <  trig_level) && (r_sample >= trig_level);
    assign w_fall      = (r_prev >= trig_level) && (r_sample <  trig_level);
    assign w_trig      = r_prev_vld && (trig_edge ? w_fall : w_rise);

    // An arm in the same cycle suppresses the write so the new capture starts clean.
    assign w_wr_en = r_sample_vld && !arm &&
                     ((r_state == ST_PRE) || (r_state == ST_WAIT_TRIG) ||
                      ((r_state == ST_POST) && w_post_more));

    // Capture sequencer: arm restarts from any state and takes priority.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pretrig   <= '0;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_trig_addr <= '0;
            r_prev      <= '0;
            r_prev_vld  <= 1'b0;
        end else if (arm) begin
            r_pretrig   <= pretrig;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_trig_addr <= '0;
            r_prev_vld  <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_state     <= (pretrig == '0) ? ST_WAIT_TRIG : ST_PRE;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case (r_state)
                ST_PRE: begin
                    if (r_sample_vld) begin
                        if (r_cnt + 1'b1 == r_pretrig) begin
                            r_cnt   <= '0;
                            r_state <= ST_WAIT_TRIG;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (r_sample_vld) begin
                        r_prev     <= r_sample;
                        r_prev_vld <= 1'b1;
                        if (w_trig) begin
                            r_trig_addr <= r_wr_ptr;
                            r_cnt       <= '0;
                            r_state     <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (!w_post_more) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_sample_vld) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr),
        .wr_data (r_sample),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign adc_clk   = r_adc_clk;
    assign busy      = r_busy;
    assign done      = r_done;
    assign trig_addr = r_trig_addr;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_capture
//  Description : Self-checking bench for adc_capture: ramp/constant ADC
//                stimulus, buffer read-back through an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_capture;
    import adc_capture_pkg::*;

    localparam int DATA_W  = 14;
    localparam int ADDR_W  = 10;
    localparam int CLK_DIV = 2;
    localparam int DEPTH   = 1024;

    logic              sys_clk = 1'b0;
    logic              rst_n   = 1'b0;
    logic              adc_clk;
    logic [DATA_W-1:0] adc_data   = '0;
    logic              arm        = 1'b0;
    logic [DATA_W-1:0] trig_level = '0;
    logic              trig_edge  = 1'b0;
    logic [ADDR_W-1:0] pretrig    = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] rd_addr    = '0;
    logic [DATA_W-1:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    // stimulus pattern: 0 constant, 1 rising ramp, 2 falling ramp (period DEPTH)
    int                mode      = 0;
    logic [DATA_W-1:0] const_val = '0;
    int                samp_idx  = 0;
    logic [DATA_W-1:0] watch_val = '0;
    logic              watch_on  = 1'b0;
    int                watch_idx = 0;
    int                done_idx  = 0;
    logic              done_d    = 1'b0;
    int                writes    = 0;
    int                wraps     = 0;

    adc_capture #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .adc_clk    (adc_clk),
        .adc_data   (adc_data),
        .arm        (arm),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .pretrig    (pretrig),
        .busy       (busy),
        .done       (done),
        .trig_addr  (trig_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ADC model: a new word appears just after each adc_clk rise, so it is
    // stable when the capture block samples it at the end of the low phase.
    initial forever begin
        @(posedge adc_clk);
        samp_idx++;
        case (mode)
            1:       adc_data = (adc_data >= DATA_W'(DEPTH - 1)) ? '0 : adc_data + 1'b1;
            2:       adc_data = (adc_data == '0) ? DATA_W'(DEPTH - 1) : adc_data - 1'b1;
            default: adc_data = const_val;
        endcase
        if (watch_on && adc_data == watch_val) begin
            watch_idx = samp_idx;
            watch_on  = 1'b0;
        end
    end

    // Monitor: done rising edge (in sample units) and buffer write activity.
    initial forever begin
        @(negedge sys_clk);
        if (done && !done_d) done_idx = samp_idx;
        done_d = done;
        if (dut.w_wr_en) begin
            writes++;
            if (dut.r_wr_ptr == ADDR_W'(DEPTH - 1)) wraps++;
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge sys_clk);
        arm = 1'b0;
    endtask

    task automatic wait_val(input string tag, input logic [DATA_W-1:0] v, input int budget);
        int n;
        n = 0;
        while (adc_data != v && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= budget) check_eq({tag, "_timeout"}, 32'(adc_data), 32'(v));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic read_word(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        exp_q.push_back(e);
        rd_addr = a;
        @(negedge sys_clk);
        check_eq(tag, 32'(rd_data), 32'(exp_q.pop_front()));
    endtask

    initial begin
        int rises, highs, bad;
        logic prev_clk;
        logic [ADDR_W-1:0] a, old_ta;

        // ---------------- reset then idle ----------------
        cycles(3);
        check_eq("rst_adc_clk", 32'(adc_clk), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_trig_addr", 32'(trig_addr), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n  = 1'b1;
        writes = 0;
        cycles(4 * CLK_DIV);
        check_eq("idle_writes", 32'(writes), 32'd0);
        rises    = 0;
        highs    = 0;
        prev_clk = adc_clk;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (adc_clk && !prev_clk) rises++;
            if (adc_clk) highs++;
            prev_clk = adc_clk;
        end
        check_eq("adc_clk_rises", 32'(rises), 32'(20 / CLK_DIV));
        check_eq("adc_clk_highs", 32'(highs), 32'(10));
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);

        // ---------------- rising trigger ----------------
        adc_data   = '0;
        mode       = 1;
        trig_level = 14'd500;
        trig_edge  = 1'b0;
        pretrig    = 10'd16;
        wait_val("rise_arm", 14'd300, 5000);
        pulse_arm();
        watch_val = 14'd500;
        watch_on  = 1'b1;
        check_eq("rise_busy", 32'(busy), 32'd1);
        check_eq("rise_done0", 32'(done), 32'd0);
        wait_done("rise", 6000);
        // trigger word captured one sample after it is driven, 1007 post
        // samples, then one more sample period for write + state update
        check_eq("rise_latency", 32'(done_idx - watch_idx), 32'(1 + 1007 + 1));
        check_eq("rise_busy_end", 32'(busy), 32'd0);
        read_word("rise_trig_word", trig_addr, 14'd500);
        for (int k = 0; k < DEPTH; k++) begin
            a = trig_addr + ADDR_W'(k) - ADDR_W'(16);
            read_word("rise_buf", a, DATA_W'((484 + k) % DEPTH));
        end

        // ---------------- falling trigger ----------------
        adc_data   = 14'd1023;
        mode       = 2;
        trig_level = 14'd100;
        trig_edge  = 1'b1;
        pretrig    = 10'd0;
        wait_val("fall_arm", 14'd600, 5000);
        pulse_arm();
        watch_val = 14'd99;
        watch_on  = 1'b1;
        check_eq("fall_busy", 32'(busy), 32'd1);
        check_eq("fall_done0", 32'(done), 32'd0);
        wait_done("fall", 6000);
        check_eq("fall_latency", 32'(done_idx - watch_idx), 32'(1 + 1023 + 1));
        read_word("fall_trig_word", trig_addr, 14'd99);
        read_word("fall_next_word", trig_addr + 1'b1, 14'd98);
        for (int k = 0; k < DEPTH; k++) begin
            a = trig_addr + ADDR_W'(k);
            read_word("fall_buf", a, DATA_W'((99 + DEPTH - k) % DEPTH));
        end

        // ---------------- re-arm mid-POST ----------------
        adc_data   = '0;
        mode       = 1;
        trig_level = 14'd500;
        trig_edge  = 1'b0;
        pretrig    = 10'd16;
        wait_val("rearm_arm", 14'd300, 5000);
        pulse_arm();
        watch_val = 14'd500;
        watch_on  = 1'b1;
        bad = 0;
        while (watch_on && bad < 5000) begin
            @(negedge sys_clk);
            bad++;
        end
        check_eq("rearm_watch", 32'(watch_on), 32'd0);
        cycles(11 * CLK_DIV);
        old_ta = trig_addr;
        check_eq("rearm_in_post", 32'(dut.r_state), 32'(ST_POST));
        trig_level = 14'd200;
        pulse_arm();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (!busy || done) bad++;
        end
        check_eq("rearm_stays_busy", 32'(bad), 32'd0);
        wait_done("rearm", 6000);
        check_eq("rearm_new_addr", 32'(trig_addr != old_ta), 32'd1);
        read_word("rearm_trig_word", trig_addr, 14'd200);
        read_word("rearm_prev_word", trig_addr - 1'b1, 14'd199);

        // ---------------- no trigger ----------------
        const_val  = 14'd50;
        mode       = 0;
        trig_level = 14'd500;
        trig_edge  = 1'b0;
        pretrig    = 10'd16;
        cycles(4);
        pulse_arm();
        wraps = 0;
        bad   = 0;
        for (int i = 0; i < 5000 * CLK_DIV; i++) begin
            @(negedge sys_clk);
            if (!busy || done) bad++;
        end
        check_eq("notrig_busy_hold", 32'(bad), 32'd0);
        check_eq("notrig_wraps_ge4", 32'(wraps >= 4), 32'd1);

        // ---------------- reset mid-WAIT_TRIG ----------------
        check_eq("midrst_pre_state", 32'(dut.r_state), 32'(ST_WAIT_TRIG));
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_state", 32'(dut.r_state), 32'(ST_IDLE));
        check_eq("midrst_adc_clk", 32'(adc_clk), 32'd0);
        check_eq("midrst_rd_data", 32'(rd_data), 32'd0);
        cycles(3);
        rst_n  = 1'b1;
        writes = 0;
        cycles(20 * CLK_DIV);
        check_eq("postrst_writes", 32'(writes), 32'd0);
        check_eq("postrst_busy", 32'(busy), 32'd0);
        check_eq("postrst_state", 32'(dut.r_state), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter DATA_W, default 14: ADC sample width, matching the DAC channel width.
REQ-002 Parameter ADDR_W, default 10: capture buffer address width; DEPTH = 2**ADDR_W samples.
REQ-003 Parameter CLK_DIV, default 2: sys_clk cycles per sample; legal range 2..255.
REQ-004 Port sys_clk, in, 1: single clock for all logic.
REQ-005 Port rst_n, in, 1: asynchronous, active-low reset.
REQ-006 Port adc_clk, out, DATA_W-independent 1: sample clock driven to the ADC.
REQ-007 Port adc_data, in, DATA_W: parallel unsigned ADC output.
REQ-008 Port arm, in, 1: single-cycle pulse that starts or restarts a capture.
REQ-009 Port trig_level, in, DATA_W: unsigned trigger threshold.
REQ-010 Port trig_edge, in, 1: trigger slope; 0 = rising, 1 = falling.
REQ-011 Port pretrig, in, ADDR_W: number of samples kept before the trigger; sampled on arm.
REQ-012 Port busy, out, 1: high while a capture is in progress.
REQ-013 Port done, out, 1: high while the buffer holds a complete capture.
REQ-014 Port trig_addr, out, ADDR_W: buffer address of the triggering sample.
REQ-015 Port rd_addr, in, ADDR_W: CPU read address.
REQ-016 Port rd_data, out, DATA_W: buffer word at rd_addr, one cycle after rd_addr.

Function
REQ-017 Divider counter runs 0..CLK_DIV-1 continuously out of reset.
REQ-018 adc_clk is high for counts < CLK_DIV/2 (integer division) and is registered.
REQ-019 sample_en pulses for one cycle at count CLK_DIV-1; adc_data is registered on that cycle only.
REQ-020 The FSM has five states: IDLE, PRE, WAIT_TRIG, POST, DONE.
REQ-021 arm in any state latches pretrig and clears wr_ptr, sample counter, done and trig_addr.
REQ-022 On arm, the FSM goes to PRE, or directly to WAIT_TRIG when pretrig = 0.
REQ-023 In PRE, WAIT_TRIG and POST, each sample_en writes the registered sample at wr_ptr; wr_ptr then increments modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-024 PRE -> WAIT_TRIG after exactly pretrig samples have been written.
REQ-025 In WAIT_TRIG, a rising trigger occurs when prev < trig_level and cur >= trig_level (unsigned compare).
REQ-026 In WAIT_TRIG, a falling trigger occurs when prev >= trig_level and cur < trig_level (unsigned compare).
REQ-027 prev is the sample before cur; the first sample written in WAIT_TRIG cannot trigger.
REQ-028 WAIT_TRIG keeps overwriting the ring indefinitely until a trigger occurs.
REQ-029 On trigger, trig_addr = the address of cur and the FSM goes to POST.
REQ-030 POST writes DEPTH-1-pretrig further samples, then goes to DONE.
REQ-031 If pretrig = DEPTH-1, POST writes zero samples and the FSM goes to DONE on the next cycle.
REQ-032 busy = 1 in PRE, WAIT_TRIG and POST.
REQ-033 done = 1 only in DONE; no writes occur in IDLE or DONE.
REQ-034 Reads are legal in any state; a read of the address being written in the same cycle returns old data.
REQ-035 arm coinciding with a trigger or a sample_en: arm wins, and that sample is not written.

Reset
REQ-036 While rst_n = 0, the FSM is in IDLE and all counters and wr_ptr are 0.
REQ-037 While rst_n = 0, the outputs are: adc_clk = 0, busy = 0, done = 0, trig_addr = 0, rd_data = 0.
REQ-038 Buffer RAM contents are not reset.
REQ-039 Reset asserted mid-capture aborts the capture; after release the block stays in IDLE until arm.

Structure
REQ-040 A shared package holds the FSM state encoding and the default DATA_W, ADDR_W and CLK_DIV constants.
REQ-041 The buffer is sub-module capture_ram: simple dual-port RAM, one write port and one registered read port, DEPTH x DATA_W.
REQ-042 RTL size is 120-400 lines, excluding capture_ram.

Verification
REQ-043 Reset then idle: the rst_n release is followed by a 4-sample interval with no writes.
REQ-044 Reset then idle: adc_clk period = 2*... = CLK_DIV sys_clk cycles, here 2 cycles; busy = done = 0.
REQ-045 Rising trigger: ramp 0..1023 repeating, pretrig = 16, level = 500, edge = 0, arm.
REQ-046 Rising trigger response: trig_addr holds value 500; the 16 preceding words are 484..499; done rises after 1007 post samples.
REQ-047 Falling trigger: descending ramp 1023..0, level = 100, edge = 1, pretrig = 0.
REQ-048 Falling trigger response: the first trigger sample is 99; buffer word trig_addr+1 = 98; exactly 1023 samples follow the trigger.
REQ-049 No trigger: constant adc_data = 50, level = 500 -> busy stays 1 and done stays 0 for 5000 samples.
REQ-050 No trigger (continued): wr_ptr wraps through 1023 -> 0 at least 4 times.
REQ-051 Re-arm mid-POST: arm 10 samples after a trigger -> busy stays 1 and done stays 0.
REQ-052 Re-arm mid-POST (continued): the new capture completes with a new trig_addr.
REQ-053 Reset mid-WAIT_TRIG: rst_n low for 3 cycles -> busy = 0 and state IDLE immediately.
REQ-054 Reset mid-WAIT_TRIG (continued): no writes occur until the next arm.
